// File: rtl/p_int_acc_seq_pkg.sv
// Shared definitions for the integer vector accumulator.
//   dconf_t        : data format (sign selects signed/unsigned, prec is the width)
//   DEF_DCONF_INT  : default format, signed 8-bit
//   acc_state_e    : accumulator FSM states
//   SAT_EN         : 1 when P_INT_ACC_SEQ_SAT_EN is defined (clamp on overflow),
//                    0 otherwise (wrap modulo 2^prec)
//   fmt_max/fmt_min: representable range of a format
package p_int_acc_seq_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] prec;
    } dconf_t;

    localparam dconf_t DEF_DCONF_INT = '{sign: 1'b1, prec: 8'd8};

`ifdef P_INT_ACC_SEQ_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } acc_state_e;

    function automatic longint fmt_max(input dconf_t c);
        return c.sign ? ((64'sd1 <<< (c.prec - 8'd1)) - 64'sd1)
                      : ((64'sd1 <<< c.prec) - 64'sd1);
    endfunction

    function automatic longint fmt_min(input dconf_t c);
        return c.sign ? -(64'sd1 <<< (c.prec - 8'd1)) : 64'sd0;
    endfunction

endpackage

// File: rtl/p_int_acc.sv
// IN-wide adder tree: reduces one beat of IN elements to a single value.
// Saturates when P_INT_ACC_SEQ_SAT_EN is defined, wraps otherwise.
//   in_data : IN elements of PREC bits in format CONF
//   sum_c   : reduced sum in format CONF (combinational)
//   ovf_c   : exact sum not representable in CONF (combinational)
module p_int_acc
    import p_int_acc_seq_pkg::*;
#(
    parameter int unsigned IN   = 8,
    parameter dconf_t      CONF = DEF_DCONF_INT,
    localparam int unsigned PREC = 32'(CONF.prec)
) (
    input  logic [IN-1:0][PREC-1:0] in_data,
    output logic [PREC-1:0]         sum_c,
    output logic                    ovf_c
);

    // Enough growth bits that the exact sum of IN elements never wraps.
    localparam int unsigned WW = PREC + 32'($clog2(IN)) + 1;
    localparam int unsigned XW = WW - PREC;
    localparam logic signed [WW-1:0] MAXV = WW'(fmt_max(CONF));
    localparam logic signed [WW-1:0] MINV = WW'(fmt_min(CONF));

    logic signed [WW-1:0] elem_w;
    logic signed [WW-1:0] sum_w;

    // Exact reduction in the wide domain; synthesis rebalances into a tree.
    always_comb begin
        sum_w  = '0;
        elem_w = '0;
        for (int unsigned i = 0; i < IN; i++) begin
            elem_w = CONF.sign ? {{XW{in_data[i][PREC-1]}}, in_data[i]}
                               : {{XW{1'b0}}, in_data[i]};
            sum_w  = sum_w + elem_w;
        end
        ovf_c = (sum_w > MAXV) || (sum_w < MINV);
        sum_c = sum_w[PREC-1:0];
        if (SAT_EN && ovf_c) begin
            sum_c = (sum_w > MAXV) ? MAXV[PREC-1:0] : MINV[PREC-1:0];
        end
    end

endmodule

// File: rtl/p_int_add.sv
// Two-operand integer adder with overflow detection in a given format.
// Saturates when P_INT_ACC_SEQ_SAT_EN is defined, wraps otherwise.
//   a, b  : operands in formats CONF_A / CONF_B
//   y_c   : result in format CONF_Y (combinational)
//   ovf_c : true sum not representable in CONF_Y (combinational)
module p_int_add
    import p_int_acc_seq_pkg::*;
#(
    parameter dconf_t CONF_A = DEF_DCONF_INT,
    parameter dconf_t CONF_B = DEF_DCONF_INT,
    parameter dconf_t CONF_Y = DEF_DCONF_INT,
    localparam int unsigned PREC = 32'(CONF_Y.prec)
) (
    input  logic [PREC-1:0] a,
    input  logic [PREC-1:0] b,
    output logic [PREC-1:0] y_c,
    output logic            ovf_c
);

    // Two guard bits hold any sum of two PREC-bit values, signed or unsigned.
    localparam int unsigned WW = PREC + 2;
    localparam logic signed [WW-1:0] MAXV = WW'(fmt_max(CONF_Y));
    localparam logic signed [WW-1:0] MINV = WW'(fmt_min(CONF_Y));

    logic signed [WW-1:0] a_w;
    logic signed [WW-1:0] b_w;
    logic signed [WW-1:0] sum_w;

    // Exact sum, range check, then wrap or clamp.
    always_comb begin
        a_w   = CONF_A.sign ? {{2{a[PREC-1]}}, a} : {2'b00, a};
        b_w   = CONF_B.sign ? {{2{b[PREC-1]}}, b} : {2'b00, b};
        sum_w = a_w + b_w;
        ovf_c = (sum_w > MAXV) || (sum_w < MINV);
        y_c   = sum_w[PREC-1:0];
        if (SAT_EN && ovf_c) begin
            y_c = (sum_w > MAXV) ? MAXV[PREC-1:0] : MINV[PREC-1:0];
        end
    end

endmodule

// File: rtl/p_int_acc_seq.sv
// Sequential vector accumulator: sums beats of IN elements into one result
// per vector, terminated by in_last or by reaching MAXBEAT beats.
// Overflow handling is selected by macro P_INT_ACC_SEQ_SAT_EN
// (defined: clamp to format range; undefined: wrap modulo 2^PREC).
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : input beat handshake; in_data elements, in_last ends vector
//   out_valid/out_ready  : result handshake
//   out_data             : vector sum
//   out_ovf              : an overflow occurred somewhere in this vector
//   out_beats            : beats accumulated
//   out_trunc            : vector was cut at MAXBEAT without in_last
module p_int_acc_seq
    import p_int_acc_seq_pkg::*;
#(
    parameter int unsigned  IN      = 8,
    parameter dconf_t       CONF    = DEF_DCONF_INT,
    parameter int unsigned  MAXBEAT = 16,
    localparam int unsigned PREC    = 32'(CONF.prec),
    localparam int unsigned BW      = 32'($clog2(MAXBEAT + 1))
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN-1:0][PREC-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PREC-1:0]         out_data,
    output logic                    out_ovf,
    output logic [BW-1:0]           out_beats,
    output logic                    out_trunc
);

    acc_state_e      state_q, state_d;
    logic [PREC-1:0] acc_q, acc_d;
    logic            ovf_q, ovf_d;
    logic [BW-1:0]   beats_q, beats_d;
    logic            trunc_q, trunc_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic [PREC-1:0] tree_sum_c;
    logic            tree_ovf_c;
    logic [PREC-1:0] add_sum_c;
    logic            add_ovf_c;
    logic            accept_c;
    logic            term_c;
    logic [BW-1:0]   beats_inc_c;

    p_int_acc #(
        .IN   (IN),
        .CONF (CONF)
    ) u_tree (
        .in_data (in_data),
        .sum_c   (tree_sum_c),
        .ovf_c   (tree_ovf_c)
    );

    // Running sum plus the current beat's reduced value.
    p_int_add #(
        .CONF_A (CONF),
        .CONF_B (CONF),
        .CONF_Y (CONF)
    ) u_add (
        .a     (acc_q),
        .b     (tree_sum_c),
        .y_c   (add_sum_c),
        .ovf_c (add_ovf_c)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        beats_d     = beats_q;
        trunc_d     = trunc_q;
        accept_c    = in_valid && in_ready_q;
        beats_inc_c = (state_q == ST_ACC) ? (beats_q + BW'(1)) : BW'(1);
        term_c      = in_last || (beats_inc_c == BW'(MAXBEAT));

        case (state_q)
            ST_IDLE, ST_ACC: begin
                if (accept_c) begin
                    if (state_q == ST_IDLE) begin
                        acc_d = tree_sum_c;
                        ovf_d = tree_ovf_c;
                    end else begin
                        acc_d = add_sum_c;
                        ovf_d = ovf_q | tree_ovf_c | add_ovf_c;
                    end
                    beats_d = beats_inc_c;
                    // A terminating beat without in_last can only be the MAXBEAT-th.
                    trunc_d = term_c && !in_last;
                    state_d = term_c ? ST_HOLD : ST_ACC;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d  = (state_d != ST_HOLD);
        out_valid_d = (state_d == ST_HOLD);
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            beats_q     <= '0;
            trunc_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            beats_q     <= beats_d;
            trunc_q     <= trunc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;
    assign out_beats = beats_q;
    assign out_trunc = trunc_q;

endmodule

// File: tb/tb_p_int_acc_seq.sv
`timescale 1ns/1ps
module tb_p_int_acc_seq;
    import p_int_acc_seq_pkg::*;

    localparam int unsigned IN      = 4;
    localparam int unsigned MAXBEAT = 4;
    localparam int unsigned PREC    = 8;
    localparam int unsigned BW      = 32'($clog2(MAXBEAT + 1));
    localparam dconf_t      CONF    = '{sign: 1'b1, prec: 8'd8};
`ifdef P_INT_ACC_SEQ_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int FMAX  = 127;
    localparam int FMIN  = -128;
    localparam int STALL = 5;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [IN-1:0][PREC-1:0] in_data = '0;
    logic                    in_last = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic [PREC-1:0]         out_data;
    logic                    out_ovf;
    logic [BW-1:0]           out_beats;
    logic                    out_trunc;

    typedef struct {
        int data;
        bit ovf;
        int beats;
        bit trunc;
    } exp_t;

    exp_t exp_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   m_acc    = 0;
    bit   m_ovf    = 1'b0;
    int   m_beats  = 0;
    int   rdy_mode = 0;
    bit   hold_exp = 1'b0;

    p_int_acc_seq #(
        .IN      (IN),
        .CONF    (CONF),
        .MAXBEAT (MAXBEAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_beats (out_beats),
        .out_trunc (out_trunc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit oor(input int x);
        return (x > FMAX) || (x < FMIN);
    endfunction

    function automatic int fmt(input int x);
        return SAT ? ((x > FMAX) ? FMAX : ((x < FMIN) ? FMIN : x))
                   : (((x + 128) & 255) - 128);
    endfunction

    // Reference model: integer arithmetic straight from the vector rules.
    task automatic model_beat(input int e[IN], input bit last);
        int t;
        int r;
        t = 0;
        for (int i = 0; i < int'(IN); i++) t += e[i];
        if (m_beats == 0) begin
            m_acc = fmt(t);
            m_ovf = oor(t);
        end else begin
            r     = m_acc + fmt(t);
            m_ovf = m_ovf | oor(t) | oor(r);
            m_acc = fmt(r);
        end
        m_beats++;
        if (last || m_beats == int'(MAXBEAT)) begin
            exp_q.push_back('{m_acc & 255, m_ovf, m_beats, !last});
            hold_exp = 1'b1;
            m_beats  = 0;
        end
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic send_beat(input int e[IN], input bit last, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_last  = last;
        for (int i = 0; i < int'(IN); i++) in_data[i] = PREC'(e[i]);
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stuck at 0 at %0t", $time);
        end else begin
            @(posedge clk);
            model_beat(e, last);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        hold_exp = 1'b0;
        m_beats  = 0;
        repeat (cycles) @(negedge clk);
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_out_data", longint'(out_data), 0);
        check("reset_out_beats", longint'(out_beats), 0);
        check("reset_out_ovf", longint'(out_ovf), 0);
        check("reset_out_trunc", longint'(out_trunc), 0);
        reset = 1'b0;
        check("in_ready_after_reset", longint'(in_ready), 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || hold_exp) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || hold_exp) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding at %0t", exp_q.size(), $time);
        end
        @(negedge clk);
    endtask

    // Consumer: always ready, random, or stall STALL cycles per result.
    initial begin
        int hc;
        hc = 0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (out_valid && hc < STALL) begin
                        out_ready = 1'b0;
                        hc++;
                    end else begin
                        out_ready = 1'b1;
                        hc = 0;
                    end
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard when a result appears, checks it stays put.
    initial begin
        bit   have;
        bit   cur_ok;
        exp_t cur;
        int   vcnt;
        have   = 1'b0;
        cur_ok = 1'b0;
        vcnt   = 0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                have = 1'b0;
                vcnt = 0;
            end else begin
                check("out_valid", longint'(out_valid), longint'(hold_exp));
                check("in_ready", longint'(in_ready), longint'(!hold_exp));
                if (out_valid) begin
                    if (!have) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            cur_ok = 1'b0;
                            $display("FAIL unexpected_result: data %0d with empty scoreboard at %0t", out_data, $time);
                        end else begin
                            cur    = exp_q.pop_front();
                            cur_ok = 1'b1;
                            check("out_data", longint'(out_data), longint'(cur.data));
                            check("out_ovf", longint'(out_ovf), longint'(cur.ovf));
                            check("out_beats", longint'(out_beats), longint'(cur.beats));
                            check("out_trunc", longint'(out_trunc), longint'(cur.trunc));
                        end
                        have = 1'b1;
                        vcnt = 0;
                    end else if (cur_ok) begin
                        check("hold_stable", longint'({out_data, out_ovf, out_beats, out_trunc}),
                              longint'({PREC'(cur.data), cur.ovf, BW'(cur.beats), cur.trunc}));
                    end
                    vcnt++;
                    if (out_ready) begin
                        if (rdy_mode == 2) check("hold_cycles", longint'(vcnt), STALL + 1);
                        have     = 1'b0;
                        hold_exp = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e[IN];
        int len;
        bit last;
        do_reset(3);

        // Single-beat vector
        send_beat('{1, 2, 3, 4}, 1'b1, 0);
        // Two beats, mixed signs
        send_beat('{10, 10, 10, 10}, 1'b0, 0);
        send_beat('{-5, -5, -5, -5}, 1'b1, 0);
        // Forced termination at MAXBEAT with overflow
        repeat (4) send_beat('{30, 30, 30, 30}, 1'b0, 0);
        // in_last on the MAXBEAT-th beat is not a truncation
        repeat (3) send_beat('{1, 1, 1, 1}, 1'b0, 0);
        send_beat('{1, 1, 1, 1}, 1'b1, 0);
        drain();

        // Result held while the next vector is already waiting
        rdy_mode = 2;
        send_beat('{1, 2, 3, 4}, 1'b1, 0);
        send_beat('{5, 5, 5, 5}, 1'b1, 0);
        drain();
        rdy_mode = 0;

        // Reset in the middle of a vector discards it
        send_beat('{7, 7, 7, 7}, 1'b0, 0);
        send_beat('{7, 7, 7, 7}, 1'b0, 0);
        do_reset(2);
        send_beat('{1, 1, 1, 1}, 1'b1, 0);
        drain();

        // Idle gaps between beats
        send_beat('{1, 0, 0, 0}, 1'b0, 3);
        send_beat('{1, 0, 0, 0}, 1'b0, 3);
        send_beat('{1, 0, 0, 0}, 1'b1, 3);
        drain();

        // Randomized vectors with a random consumer
        rdy_mode = 1;
        for (int v = 0; v < 60; v++) begin
            len = int'($urandom_range(1, MAXBEAT));
            for (int b = 0; b < len; b++) begin
                for (int i = 0; i < int'(IN); i++) begin
                    if ($urandom_range(0, 1) == 0) e[i] = int'($urandom_range(0, 16)) - 8;
                    else e[i] = int'($urandom_range(0, 255)) - 128;
                end
                if (b != len - 1) last = 1'b0;
                else if (len < int'(MAXBEAT)) last = 1'b1;
                else last = 1'($urandom_range(0, 1));
                send_beat(e, last, int'($urandom_range(0, 2)));
            end
        end
        drain();
        rdy_mode = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
